video_sink: RTL and testbench
=============================

# video_sink

AXI4-Stream video receiver that terminates a raster stream driven by the `video_img` source (24-bit pixels, `tuser` = start-of-frame, `tlast` = end-of-line). It frames the stream into lines and frames and writes a top-left capture window into a write-only BRAM port. It also counts frames and flags SOF/EOL protocol errors. It sits at the far end of the video pipeline, for loopback checks and frame capture.

## Interface

Parameters:
- `DATAW`, 24, pixel width.
- `SCRW`, 1920, pixels per line.
- `SCRH`, 1080, lines per frame.
- `IMGW`, 320, capture window width; must be ≤ SCRW.
- `IMGH`, 240, capture window height; must be ≤ SCRH.
- `ADDRW`, 17, BRAM address width; IMGW*IMGH ≤ 2^ADDRW.

Ports:
- `clk`  in  1  sole clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `en`  in  1  enables reception.
- `err_clr`  in  1  one-cycle pulse; clears the sticky error flags.
- `s_axis_tdata`  in  DATAW  pixel.
- `s_axis_tvalid`  in  1  beat valid.
- `s_axis_tready`  out  1  beat ready.
- `s_axis_tuser`  in  1  SOF, marks pixel (0,0).
- `s_axis_tlast`  in  1  EOL, marks the last pixel of a line.
- `bram_we_o`  out  1  BRAM write enable.
- `bram_addr_o`  out  ADDRW  BRAM write address.
- `bram_data_o`  out  DATAW  BRAM write data.
- `frame_done_o`  out  1  one-cycle pulse when a frame completes.
- `frame_cnt_o`  out  16  count of completed frames; wraps.
- `sof_err_o`  out  1  sticky flag: unexpected SOF.
- `eol_err_o`  out  1  sticky flag: EOL missing or misplaced.

## Operation

- Accept: a beat is accepted when `s_axis_tvalid && s_axis_tready`. Nothing else advances the counters.
- Counters: `x` runs 0..SCRW-1; `y` runs 0..SCRH-1; a row base register holds y*IMGW and is updated by adding IMGW, with no multiplier.
- State IDLE:
  - `s_axis_tready` = 0.
  - `en` = 1 → WAIT_SOF.
- State WAIT_SOF:
  - `s_axis_tready` = 1.
  - Accepted beats with `tuser` = 0 are discarded; no flag is raised.
  - Accepted beat with `tuser` = 1 is pixel (0,0): the beat is processed and the state goes to ACTIVE.
  - `en` = 0 with no beat accepted → IDLE.
- State ACTIVE:
  - `s_axis_tready` = 1.
  - Each accepted beat is pixel (x,y).
- Line and frame handling for each accepted beat in ACTIVE:
  - `tuser` = 1 at any position other than (0,0): set `sof_err_o`, treat the beat as pixel (0,0) of a new frame. The old frame does not count.
  - `tlast` = 1 with x < SCRW-1 (early EOL): set `eol_err_o`, close the line.
  - x = SCRW-1 with `tlast` = 0 (missing EOL): set `eol_err_o`, close the line.
  - Closing a line: x ← 0, y ← y+1, row base += IMGW.
  - Closing a line at y = SCRH-1: frame complete. Pulse `frame_done_o`, increment `frame_cnt_o`, clear x, y and row base.
  - After frame complete, next state is WAIT_SOF if `en` = 1, else IDLE.
  - Lowering `en` mid-frame does not abort the frame; it only takes effect at the frame boundary.
- Capture: an accepted pixel with x < IMGW and y < IMGH produces one write, `addr` = rowbase + x, `data` = `tdata`.
- Flags: `err_clr` clears both flags. If an error event and `err_clr` occur in the same cycle, the set wins.

## Timing

- Reset (`rstn` low, asynchronous): state IDLE, x = y = 0, all outputs 0, including `s_axis_tready`, `frame_cnt_o` and both flags.
- `s_axis_tready` is decoded from the registered state only, with no combinational path from inputs.
  - It rises 1 cycle after `en` is sampled high in IDLE.
  - It falls 1 cycle after the WAIT_SOF → IDLE transition.
- BRAM write: `bram_we_o`, `bram_addr_o` and `bram_data_o` are registered and appear 1 cycle after the accepting edge. `bram_we_o` is high for exactly 1 cycle per captured pixel.
- `frame_done_o`, `frame_cnt_o` and the flags update 1 cycle after the accepting edge.
- Throughput: 1 pixel per cycle, no bubbles.
- Reset mid-frame: everything clears immediately; after reset, the first frame is taken from the next SOF.

## Test plan

Sim parameters: SCRW=8, SCRH=4, IMGW=4, IMGH=2, ADDRW=3.

- Clean frame, tvalid held high, `tdata` = y*8+x → 32 accepts in 32 cycles. Writes at addr 0..7 with data 0,1,2,3,8,9,10,11. One `frame_done_o` pulse; `frame_cnt_o` = 1; no flags.
- Random tvalid gaps (stall pattern like the source bench), 3 frames → same write sequence each frame; `frame_cnt_o` = 3; no write while tvalid = 0.
- Leading junk: 5 beats with `tuser` = 0, then a clean frame → the junk is never written; no flags; `frame_cnt_o` = 1.
- Early EOL: `tlast` at x=5 on line 1 → `eol_err_o` = 1. The next beat is written as (0,2), i.e. not captured. The frame still ends after line 3. `err_clr` → flag 0.
- SOF injected at (3,2) → `sof_err_o` = 1, no `frame_done_o` for the aborted frame. The beat is written to addr 0; a full frame follows, then `frame_cnt_o` increments.
- `en` dropped at pixel (2,1) → the frame completes, `frame_done_o` pulses, `s_axis_tready` goes low 1 cycle later. Asserting `rstn` low mid-frame → all outputs 0 immediately.

Source files
------------

// File: rtl/video_sink.sv
// AXI4-Stream raster receiver: frames the stream into lines/frames, captures a
// top-left window into a write-only BRAM port, counts frames and flags SOF/EOL errors.
module video_sink #(
  parameter int unsigned DATAW = 24,
  parameter int unsigned SCRW  = 1920,
  parameter int unsigned SCRH  = 1080,
  parameter int unsigned IMGW  = 320,
  parameter int unsigned IMGH  = 240,
  parameter int unsigned ADDRW = 17
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             err_clr,
  input  logic [DATAW-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tlast,
  output logic             bram_we_o,
  output logic [ADDRW-1:0] bram_addr_o,
  output logic [DATAW-1:0] bram_data_o,
  output logic             frame_done_o,
  output logic [15:0]      frame_cnt_o,
  output logic             sof_err_o,
  output logic             eol_err_o
);

  localparam int unsigned XW = (SCRW > 1) ? $clog2(SCRW) : 1;
  localparam int unsigned YW = (SCRH > 1) ? $clog2(SCRH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE} state_t;

  state_t           state, state_nx;
  logic [XW-1:0]    x_q, x_nx, cx;
  logic [YW-1:0]    y_q, y_nx, cy;
  logic [ADDRW-1:0] row_q, row_nx, crow;
  logic             accept, take, last_col, close_line;
  logic             capture, sof_ev, eol_ev, frame_end;

  assign s_axis_tready = (state == WAIT_SOF) || (state == ACTIVE);
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_nx   = state;
    x_nx       = x_q;
    y_nx       = y_q;
    row_nx     = row_q;
    cx         = x_q;
    cy         = y_q;
    crow       = row_q;
    take       = 1'b0;
    last_col   = 1'b0;
    close_line = 1'b0;
    capture    = 1'b0;
    sof_ev     = 1'b0;
    eol_ev     = 1'b0;
    frame_end  = 1'b0;

    case (state)
      IDLE: if (en) state_nx = WAIT_SOF;
      WAIT_SOF: begin
        if (accept && s_axis_tuser) begin
          take     = 1'b1;
          state_nx = ACTIVE;
        end else if (!en && !accept) begin
          state_nx = IDLE;
        end
      end
      ACTIVE: begin
        if (accept) begin
          take   = 1'b1;
          sof_ev = s_axis_tuser && ((x_q != '0) || (y_q != '0));
        end
      end
      default: state_nx = IDLE;
    endcase

    // A SOF beat is always pixel (0,0); mid-frame it restarts the raster.
    if (take) begin
      if (s_axis_tuser) begin
        cx   = '0;
        cy   = '0;
        crow = '0;
      end
      last_col   = (32'(cx) == SCRW - 1);
      close_line = s_axis_tlast || last_col;
      eol_ev     = (s_axis_tlast != last_col);
      capture    = (32'(cx) < IMGW) && (32'(cy) < IMGH);
      if (close_line) begin
        if (32'(cy) == SCRH - 1) begin
          frame_end = 1'b1;
          x_nx      = '0;
          y_nx      = '0;
          row_nx    = '0;
          state_nx  = en ? WAIT_SOF : IDLE;
        end else begin
          x_nx   = '0;
          y_nx   = cy + YW'(1);
          row_nx = crow + ADDRW'(IMGW);
        end
      end else begin
        x_nx   = cx + XW'(1);
        y_nx   = cy;
        row_nx = crow;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      row_q        <= '0;
      bram_we_o    <= 1'b0;
      bram_addr_o  <= '0;
      bram_data_o  <= '0;
      frame_done_o <= 1'b0;
      frame_cnt_o  <= '0;
      sof_err_o    <= 1'b0;
      eol_err_o    <= 1'b0;
    end else begin
      state        <= state_nx;
      x_q          <= x_nx;
      y_q          <= y_nx;
      row_q        <= row_nx;
      bram_we_o    <= capture;
      if (capture) begin
        bram_addr_o <= crow + ADDRW'(cx);
        bram_data_o <= s_axis_tdata;
      end
      frame_done_o <= frame_end;
      if (frame_end) frame_cnt_o <= frame_cnt_o + 16'd1;
      sof_err_o    <= sof_ev || (sof_err_o && !err_clr);
      eol_err_o    <= eol_ev || (eol_err_o && !err_clr);
    end
  end

endmodule

// File: tb/tb_video_sink.sv
// Self-checking bench for video_sink: random stalls/data against an integer raster model.
module tb_video_sink;

  localparam int DATAW = 24;
  localparam int SCRW  = 8;
  localparam int SCRH  = 4;
  localparam int IMGW  = 4;
  localparam int IMGH  = 2;
  localparam int ADDRW = 3;
  localparam int WRW   = ADDRW + DATAW;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             en = 1'b0;
  logic             err_clr = 1'b0;
  logic [DATAW-1:0] s_axis_tdata = '0;
  logic             s_axis_tvalid = 1'b0;
  logic             s_axis_tready;
  logic             s_axis_tuser = 1'b0;
  logic             s_axis_tlast = 1'b0;
  logic             bram_we_o;
  logic [ADDRW-1:0] bram_addr_o;
  logic [DATAW-1:0] bram_data_o;
  logic             frame_done_o;
  logic [15:0]      frame_cnt_o;
  logic             sof_err_o;
  logic             eol_err_o;

  video_sink #(
    .DATAW(DATAW), .SCRW(SCRW), .SCRH(SCRH),
    .IMGW(IMGW), .IMGH(IMGH), .ADDRW(ADDRW)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .err_clr(err_clr),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .bram_we_o(bram_we_o),
    .bram_addr_o(bram_addr_o), .bram_data_o(bram_data_o),
    .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o),
    .sof_err_o(sof_err_o), .eol_err_o(eol_err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic en_r = 1'b0;
  logic clr_r = 1'b0;

  typedef struct {
    logic [DATAW-1:0] d;
    logic             u;
    logic             l;
  } beat_t;
  beat_t bq[$];

  // Reference model: mode 0 = idle, 1 = hunting SOF, 2 = in frame.
  int m_mode, m_x, m_y, m_cnt, m_done, act_done;
  bit m_acc, m_sof, m_eol, ev_sof, ev_eol;
  logic [WRW-1:0] exp_wr[$];
  logic [WRW-1:0] act_wr[$];

  always @(negedge clk) begin
    if (rstn) begin
      if (bram_we_o) act_wr.push_back({bram_addr_o, bram_data_o});
      if (frame_done_o) act_done++;
    end
  end

  task automatic model_reset();
    m_mode = 0; m_x = 0; m_y = 0; m_cnt = 0; m_done = 0;
    m_sof = 0; m_eol = 0; m_acc = 0;
    exp_wr.delete(); act_wr.delete(); act_done = 0;
  endtask

  task automatic model_pixel(input bit in_frame);
    bit at_end;
    if (s_axis_tuser) begin
      if (in_frame && (m_x != 0 || m_y != 0)) ev_sof = 1;
      m_x = 0; m_y = 0;
    end
    if (m_x < IMGW && m_y < IMGH)
      exp_wr.push_back({ADDRW'(m_y * IMGW + m_x), s_axis_tdata});
    at_end = (m_x == SCRW - 1);
    if (s_axis_tlast != at_end) ev_eol = 1;
    if (s_axis_tlast || at_end) begin
      m_x = 0;
      m_y++;
      if (m_y == SCRH) begin
        m_y = 0; m_cnt++; m_done++;
        m_mode = en ? 1 : 0;
      end
    end else begin
      m_x++;
    end
  endtask

  task automatic model_step();
    ev_sof = 0; ev_eol = 0;
    m_acc = s_axis_tvalid && (m_mode != 0);
    case (m_mode)
      0: if (en) m_mode = 1;
      1: begin
        if (m_acc && s_axis_tuser) begin
          m_mode = 2;
          model_pixel(0);
        end else if (!en && !m_acc) begin
          m_mode = 0;
        end
      end
      default: if (m_acc) model_pixel(1);
    endcase
    m_sof = ev_sof || (m_sof && !err_clr);
    m_eol = ev_eol || (m_eol && !err_clr);
  endtask

  task automatic tick(input logic v, input logic [DATAW-1:0] d, input logic u, input logic l);
    @(negedge clk);
    s_axis_tvalid = v; s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l;
    en = en_r; err_clr = clr_r;
    model_step();
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 24'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic run(input int gap_max, input int drop_idx);
    for (int i = 0; i < bq.size(); i++) begin
      int tries;
      if (i == drop_idx) en_r = 1'b0;
      if (gap_max > 0) idle($urandom_range(0, gap_max));
      tries = 0;
      do begin
        tick(1'b1, bq[i].d, bq[i].u, bq[i].l);
        tries++;
      end while (!m_acc && tries < 8);
      if (!m_acc) begin
        n_chk++; n_fail++;
        $display("FAIL beat_accept_timeout: beat %0d not accepted after %0d cycles", i, tries);
      end
    end
    bq.delete();
  endtask

  task automatic add_frame(input int eol_line, input int eol_x, input bit rnd);
    for (int y = 0; y < SCRH; y++)
      for (int x = 0; x < SCRW; x++) begin
        beat_t b;
        if (y == eol_line && x > eol_x) continue;
        b.d = rnd ? 24'($urandom) : 24'(y * SCRW + x);
        b.u = (x == 0 && y == 0);
        b.l = (x == SCRW - 1) || (y == eol_line && x == eol_x);
        bq.push_back(b);
      end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; en_r = 1'b0; clr_r = 1'b0; en = 1'b0; err_clr = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    logic [WRW+21:0] outs;
    do_reset();
    outs = {s_axis_tready, bram_we_o, bram_addr_o, bram_data_o, frame_done_o, frame_cnt_o, sof_err_o, eol_err_o};
    n_chk++; if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outs); end
    idle(1); #1;
    n_chk++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %b want 0", s_axis_tready); end
    en_r = 1'b1;
    idle(1); #1;
    n_chk++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL ready_rise: got %b want 1", s_axis_tready); end
    en_r = 1'b0;
    idle(1); #1;
    n_chk++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL ready_fall: got %b want 0", s_axis_tready); end
  endtask

  task automatic test_clean();
    int c0;
    beat_t first;
    do_reset();
    en_r = 1'b1; idle(1);
    c0 = cyc;
    add_frame(-1, -1, 0);
    first = bq.pop_front();
    bq.push_front(first);
    while (bq.size() > 1) void'(bq.pop_back());
    run(0, -1); #1;
    n_chk++; if ({bram_we_o, bram_addr_o, bram_data_o} !== {1'b1, {WRW{1'b0}}}) begin
      n_fail++; $display("FAIL first_write: got we=%b addr=%0d data=%0d want we=1 addr=0 data=0", bram_we_o, bram_addr_o, bram_data_o); end
    add_frame(-1, -1, 0);
    void'(bq.pop_front());
    run(0, -1); #1;
    n_chk++; if (cyc - c0 !== 32) begin n_fail++; $display("FAIL clean_cycles: got %0d want 32", cyc - c0); end
    n_chk++; if ({frame_done_o, frame_cnt_o} !== {1'b1, 16'd1}) begin
      n_fail++; $display("FAIL clean_done: got done=%b cnt=%0d want done=1 cnt=1", frame_done_o, frame_cnt_o); end
    idle(2); #1;
    n_chk++; if (act_wr.size() != 8) begin n_fail++; $display("FAIL clean_wr_count: got %0d want 8", act_wr.size()); end
    for (int i = 0; i < act_wr.size() && i < 8; i++) begin
      logic [WRW-1:0] want;
      want = {ADDRW'(i), DATAW'((i / IMGW) * SCRW + i % IMGW)};
      n_chk++; if (act_wr[i] !== want || act_wr[i] !== exp_wr[i]) begin
        n_fail++; $display("FAIL clean_wr[%0d]: got %h want %h", i, act_wr[i], want); end
    end
    n_chk++; if ({act_done, sof_err_o, eol_err_o} !== {32'd1, 2'b00}) begin
      n_fail++; $display("FAIL clean_status: got done_pulses=%0d sof=%b eol=%b want 1 0 0", act_done, sof_err_o, eol_err_o); end
  endtask

  task automatic test_stall();
    do_reset();
    en_r = 1'b1; idle(1);
    repeat (3) add_frame(-1, -1, 0);
    run(3, -1);
    idle(2); #1;
    n_chk++; if (act_wr.size() != 24 || exp_wr.size() != 24) begin
      n_fail++; $display("FAIL stall_wr_count: got %0d want 24", act_wr.size()); end
    for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++) begin
      n_chk++; if (act_wr[i] !== exp_wr[i]) begin n_fail++; $display("FAIL stall_wr[%0d]: got %h want %h", i, act_wr[i], exp_wr[i]); end
    end
    n_chk++; if ({frame_cnt_o, sof_err_o, eol_err_o} !== {16'd3, 2'b00} || act_done != m_done) begin
      n_fail++; $display("FAIL stall_status: got cnt=%0d pulses=%0d sof=%b eol=%b want cnt=3 pulses=%0d no flags",
                         frame_cnt_o, act_done, sof_err_o, eol_err_o, m_done); end
  endtask

  task automatic test_junk();
    do_reset();
    en_r = 1'b1; idle(1);
    repeat (5) begin
      beat_t b;
      b.d = 24'($urandom); b.u = 1'b0; b.l = 1'($urandom);
      bq.push_back(b);
    end
    add_frame(-1, -1, 0);
    run(1, -1);
    idle(2); #1;
    n_chk++; if (act_wr.size() != exp_wr.size() || exp_wr.size() != 8) begin
      n_fail++; $display("FAIL junk_wr_count: got %0d want 8", act_wr.size()); end
    for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++) begin
      n_chk++; if (act_wr[i] !== exp_wr[i]) begin n_fail++; $display("FAIL junk_wr[%0d]: got %h want %h", i, act_wr[i], exp_wr[i]); end
    end
    n_chk++; if ({frame_cnt_o, sof_err_o, eol_err_o} !== {16'd1, 2'b00}) begin
      n_fail++; $display("FAIL junk_status: got cnt=%0d sof=%b eol=%b want 1 0 0", frame_cnt_o, sof_err_o, eol_err_o); end
  endtask

  task automatic test_early_eol();
    do_reset();
    en_r = 1'b1; idle(1);
    add_frame(1, 5, 0);
    run(2, -1);
    idle(2); #1;
    n_chk++; if (act_wr.size() != exp_wr.size() || exp_wr.size() != 8) begin
      n_fail++; $display("FAIL eol_wr_count: got %0d want 8", act_wr.size()); end
    for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++) begin
      n_chk++; if (act_wr[i] !== exp_wr[i]) begin n_fail++; $display("FAIL eol_wr[%0d]: got %h want %h", i, act_wr[i], exp_wr[i]); end
    end
    n_chk++; if ({eol_err_o, sof_err_o, frame_cnt_o} !== {m_eol, m_sof, 16'(m_cnt)} || m_eol != 1 || m_cnt != 1) begin
      n_fail++; $display("FAIL eol_flag: got eol=%b sof=%b cnt=%0d want eol=1 sof=0 cnt=1", eol_err_o, sof_err_o, frame_cnt_o); end
    clr_r = 1'b1; idle(1); clr_r = 1'b0; #1;
    n_chk++; if (eol_err_o !== 1'b0) begin n_fail++; $display("FAIL eol_clear: got %b want 0", eol_err_o); end
  endtask

  task automatic test_sof_inject();
    do_reset();
    en_r = 1'b1; idle(1);
    for (int i = 0; i < 2 * SCRW + 3; i++) begin
      beat_t b;
      b.d = 24'($urandom); b.u = (i == 0); b.l = ((i % SCRW) == SCRW - 1);
      bq.push_back(b);
    end
    run(1, -1); #1;
    n_chk++; if (frame_cnt_o !== 16'd0 || sof_err_o !== 1'b0) begin
      n_fail++; $display("FAIL sof_before: got cnt=%0d sof=%b want 0 0", frame_cnt_o, sof_err_o); end
    add_frame(-1, -1, 1);
    run(1, -1);
    idle(2); #1;
    n_chk++; if (act_wr.size() != exp_wr.size() || exp_wr.size() != 16) begin
      n_fail++; $display("FAIL sof_wr_count: got %0d want 16", act_wr.size()); end
    for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++) begin
      n_chk++; if (act_wr[i] !== exp_wr[i]) begin n_fail++; $display("FAIL sof_wr[%0d]: got %h want %h", i, act_wr[i], exp_wr[i]); end
    end
    if (act_wr.size() > 8) begin
      logic [WRW-1:0] w;
      w = act_wr[8];
      n_chk++; if (w[WRW-1:DATAW] !== '0) begin n_fail++; $display("FAIL sof_restart_addr: got %0d want 0", w[WRW-1:DATAW]); end
    end
    n_chk++; if ({sof_err_o, eol_err_o, frame_cnt_o} !== {2'b10, 16'd1} || act_done != 1) begin
      n_fail++; $display("FAIL sof_status: got sof=%b eol=%b cnt=%0d pulses=%0d want 1 0 1 1", sof_err_o, eol_err_o, frame_cnt_o, act_done); end
  endtask

  task automatic test_en_drop();
    do_reset();
    en_r = 1'b1; idle(1);
    add_frame(-1, -1, 1);
    run(0, SCRW + 2); #1;
    n_chk++; if ({frame_done_o, s_axis_tready, frame_cnt_o} !== {2'b10, 16'd1} || m_mode != 0) begin
      n_fail++; $display("FAIL en_drop_end: got done=%b ready=%b cnt=%0d want done=1 ready=0 cnt=1", frame_done_o, s_axis_tready, frame_cnt_o); end
    idle(2); #1;
    n_chk++; if (act_wr.size() != exp_wr.size() || act_done != 1) begin
      n_fail++; $display("FAIL en_drop_writes: got %0d writes %0d pulses want %0d writes 1 pulse", act_wr.size(), act_done, exp_wr.size()); end
    for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++) begin
      n_chk++; if (act_wr[i] !== exp_wr[i]) begin n_fail++; $display("FAIL en_drop_wr[%0d]: got %h want %h", i, act_wr[i], exp_wr[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [WRW+21:0] outs;
    do_reset();
    en_r = 1'b1; idle(1);
    for (int i = 0; i < 10; i++) begin
      beat_t b;
      b.d = 24'($urandom); b.u = (i == 0) || (i == 6); b.l = 1'b0;
      bq.push_back(b);
    end
    run(0, -1); #1;
    n_chk++; if (sof_err_o !== 1'b1 || bram_we_o !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre_reset: got sof=%b we=%b want 1 1", sof_err_o, bram_we_o); end
    #1 rstn = 1'b0;
    #1;
    outs = {s_axis_tready, bram_we_o, bram_addr_o, bram_data_o, frame_done_o, frame_cnt_o, sof_err_o, eol_err_o};
    n_chk++; if (outs !== '0) begin n_fail++; $display("FAIL mid_reset_outputs: got %h want 0", outs); end
    model_reset();
    en_r = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    en_r = 1'b1; idle(1);
    for (int i = 0; i < 4; i++) begin
      beat_t b;
      b.d = 24'($urandom); b.u = 1'b0; b.l = (i == 3);
      bq.push_back(b);
    end
    add_frame(-1, -1, 0);
    run(2, -1);
    idle(2); #1;
    n_chk++; if (act_wr.size() != exp_wr.size() || exp_wr.size() != 8) begin
      n_fail++; $display("FAIL mid_wr_count: got %0d want 8", act_wr.size()); end
    for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++) begin
      n_chk++; if (act_wr[i] !== exp_wr[i]) begin n_fail++; $display("FAIL mid_wr[%0d]: got %h want %h", i, act_wr[i], exp_wr[i]); end
    end
    n_chk++; if ({frame_cnt_o, sof_err_o, eol_err_o} !== {16'd1, 2'b00}) begin
      n_fail++; $display("FAIL mid_status: got cnt=%0d sof=%b eol=%b want 1 0 0", frame_cnt_o, sof_err_o, eol_err_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean();
    test_stall();
    test_junk();
    test_early_eol();
    test_sof_inject();
    test_en_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
